// File: rtl/lcd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_ctrl -- HD44780-style character-LCD write controller
//
// Sits between the processor output port and the LCD pins. The processor
// hands over one command or data byte per valid/ready handshake. The
// controller then drives the register-select and data lines, generates the
// enable strobe, holds the bus, and waits out the LCD execution time before
// it accepts the next byte. All intervals are cycle counts of clk.
//
// Optional feature (compile-time macro LCD_INIT_EN):
//   When defined, the controller performs the LCD power-on initialisation
//   itself: a power-on wait followed by the command writes 0x38, 0x38, 0x38,
//   0x0C, 0x06, 0x01. Requests are only accepted once this has finished.
//   When undefined, software performs the initialisation and the controller
//   is ready on the first clock edge after reset is released.
//
// Parameters:
//   CNT_W    width of the interval counter (every T_* <= 2**CNT_W-1)
//   T_SETUP  cycles RS/data are stable before LCD_EN rises        (>= 1)
//   T_EN     cycles LCD_EN is high                                 (>= 1)
//   T_HOLD   cycles RS/data are held after LCD_EN falls            (>= 1)
//   T_CMD    execution wait after an ordinary command/data write   (>= 1)
//   T_CLR    execution wait after clear (0x01) / home (0x02), RS=0 (>= 1)
//   T_PWR    power-on wait before the init writes (LCD_INIT_EN only)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   wr_valid   requester has a byte to write
//   wr_rs      0 = command, 1 = data
//   wr_data    byte to write
//   wr_ready   controller idle; transfer happens on wr_valid & wr_ready
//   init_done  initialisation complete
//   LCD_Data   LCD data bus (registered)
//   LCD_EN     LCD enable strobe (registered)
//   LCD_RS     LCD register select (registered)
//   LCD_RW     read/write select, always write (0)
//   LCD_on     display power enable, always 1
// ---------------------------------------------------------------------------
module lcd_ctrl #(
  parameter int CNT_W   = 20,
  parameter int T_SETUP = 4,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 4,
  parameter int T_CMD   = 2500,
  parameter int T_CLR   = 100000,
  parameter int T_PWR   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic [7:0] LCD_Data,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_on
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } state_t;

  // Each state lasts N cycles: the counter is loaded with N-1 on entry,
  // counts down, and the state is left on the cycle it reads zero.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);
  localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(T_PWR - 1);

`ifdef LCD_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  // With the built-in init the controller wakes up in the power-on wait;
  // without it, it goes straight to IDLE and announces readiness one edge
  // after reset is released.
  localparam state_t           RESET_STATE = INIT_EN ? PWR_WAIT : IDLE;
  localparam logic [CNT_W-1:0] RESET_CNT   = INIT_EN ? LD_PWR : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             long_wait;
  logic             more_init;
  logic [7:0]       first_byte;
  logic [7:0]       next_byte;

`ifdef LCD_INIT_EN
  localparam logic [2:0] LAST_IDX = 3'd5;

  logic [2:0] init_idx;

  // Power-on command sequence: three function-set writes (8-bit bus,
  // two lines, 5x8 font), display on, entry mode increment, clear.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h38;
      3'd2:    init_byte = 8'h38;
      3'd3:    init_byte = 8'h0C;
      3'd4:    init_byte = 8'h06;
      3'd5:    init_byte = 8'h01;
      default: init_byte = 8'h00;
    endcase
  endfunction

  // Another init step follows the current WAIT until the last table entry
  // has been written; after that the controller hands over to the requester.
  assign more_init  = !init_done && (init_idx != LAST_IDX);
  assign first_byte = init_byte(3'd0);
  assign next_byte  = init_byte(init_idx + 3'd1);
`else
  assign more_init  = 1'b0;
  assign first_byte = 8'h00;
  assign next_byte  = 8'h00;
`endif

  assign cnt_zero = (cnt == '0);

  // Clear and home are the slow LCD instructions; they only count as such
  // when written as commands, a data byte of the same value is ordinary.
  assign long_wait = !LCD_RS && ((LCD_Data == 8'h01) || (LCD_Data == 8'h02));

  assign LCD_RW = 1'b0;
  assign LCD_on = 1'b1;

  // Write sequencer. RS and data are latched on accept (or on an init step)
  // and stay put through SETUP, PULSE, HOLD and WAIT, and also through IDLE
  // until the next write, so the bus only ever changes before a setup
  // interval. LCD_EN is registered and cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_STATE;
      cnt       <= RESET_CNT;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
      LCD_Data  <= 8'h00;
      LCD_RS    <= 1'b0;
      LCD_EN    <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx  <= 3'd0;
`endif
    end else begin
      case (state)
        PWR_WAIT: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else if (INIT_EN) begin
            LCD_Data <= first_byte;
            LCD_RS   <= 1'b0;
            cnt      <= LD_SETUP;
            state    <= SETUP;
          end else begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (!init_done) begin
            // Only reachable without the built-in init: the first edge
            // after reset simply declares the controller ready.
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
          end else if (wr_valid) begin
            LCD_Data <= wr_data;
            LCD_RS   <= wr_rs;
            wr_ready <= 1'b0;
            cnt      <= LD_SETUP;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            LCD_EN <= 1'b1;
            cnt    <= LD_EN;
            state  <= PULSE;
          end
        end

        PULSE: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            LCD_EN <= 1'b0;
            cnt    <= LD_HOLD;
            state  <= HOLD;
          end
        end

        HOLD: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt   <= long_wait ? LD_CLR : LD_CMD;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else if (more_init) begin
            // Init steps chain directly into the next setup interval
            // without passing through IDLE.
`ifdef LCD_INIT_EN
            init_idx <= init_idx + 3'd1;
`endif
            LCD_Data <= next_byte;
            LCD_RS   <= 1'b0;
            cnt      <= LD_SETUP;
            state    <= SETUP;
          end else begin
            wr_ready  <= 1'b1;
            init_done <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          LCD_EN   <= 1'b0;
          wr_ready <= 1'b0;
          cnt      <= RESET_CNT;
          state    <= RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_ctrl -- self-checking bench for lcd_ctrl
//
// The bench logs every output once per cycle (on the falling edge) and, for
// each group of writes, builds the expected timeline from the interface
// rules: a write accepted on edge a shows its RS/data from cycle a on, has
// LCD_EN high for T_EN cycles starting T_SETUP cycles later, and leaves the
// controller busy for T_SETUP+T_EN+T_HOLD+wait cycles, where the wait is
// T_CLR for a clear/home command and T_CMD otherwise. Accept edges are
// predicted from the request edge and the previous busy interval.
// Cycle numbers below are the count of rising edges seen so far.
// Define LCD_INIT_EN for this file and the design to exercise the built-in
// power-on initialisation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_ctrl;

  localparam int S    = 2;
  localparam int E    = 3;
  localparam int H    = 2;
  localparam int TC   = 5;
  localparam int TL   = 20;
  localparam int TP   = 10;
  localparam int MAXC = 4096;
  localparam int MAXT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       init_done;
  logic [7:0] LCD_Data;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_on;

  lcd_ctrl #(
    .CNT_W(8), .T_SETUP(S), .T_EN(E), .T_HOLD(H),
    .T_CMD(TC), .T_CLR(TL), .T_PWR(TP)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_rs(wr_rs),
    .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done),
    .LCD_Data(LCD_Data), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_on(LCD_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       log_en    [MAXC];
  logic       log_rs    [MAXC];
  logic       log_ready [MAXC];
  logic       log_done  [MAXC];
  logic [7:0] log_data  [MAXC];

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      log_en[cyc]    <= LCD_EN;
      log_rs[cyc]    <= LCD_RS;
      log_ready[cyc] <= wr_ready;
      log_done[cyc]  <= init_done;
      log_data[cyc]  <= LCD_Data;
    end
  end

  int tests = 0;
  int fails = 0;

  // Expected write timeline (accept edge, RS, data) for the current group.
  int         t_a    [MAXT];
  logic       t_rs   [MAXT];
  logic [7:0] t_data [MAXT];
  int         nt = 0;
  int         done_from = 0;

  // Stimulus for the current group: byte, RS, idle gap after its accept.
  logic       s_rs   [MAXT];
  logic [7:0] s_data [MAXT];
  int         s_gap  [MAXT];
  int         obs_acc[MAXT];
  int         ns = 0;

`ifdef LCD_INIT_EN
  logic [7:0] init_tbl [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int busyLen(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && (d == 8'h01 || d == 8'h02)) ? TL : TC;
    return S + E + H + w;
  endfunction

  // Presents one byte and holds wr_valid until the handshake completes.
  // Returns the edge the request was first visible on and the accept edge.
  task automatic applyStimulus(input logic rs, input logic [7:0] d, output int req, output int acc);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    req = cyc + 1;
    acc = -1;
    while (acc < 0 && n < 400) begin
      @(negedge clk);
      if (wr_ready === 1'b1) acc = cyc + 1;
      n++;
    end
    if (acc < 0) checkOutput("accept_timeout", wr_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkTimeline(input string name);
    int last_end;
    last_end = t_a[nt-1] + busyLen(t_rs[nt-1], t_data[nt-1]);
    while (cyc <= last_end + 1) @(posedge clk);
    #1;
    for (int c = t_a[0]; c <= last_end && c < MAXC; c++) begin
      int   k;
      int   rise;
      logic exp_en;
      logic exp_ready;
      k = 0;
      for (int i = 0; i < nt; i++) if (t_a[i] <= c) k = i;
      rise      = t_a[k] + S;
      exp_en    = (c >= rise) && (c < rise + E);
      exp_ready = (c >= t_a[k] + busyLen(t_rs[k], t_data[k]));
      checkOutput($sformatf("%s_en@%0d", name, c), log_en[c], exp_en);
      checkOutput($sformatf("%s_ready@%0d", name, c), log_ready[c], exp_ready);
      checkOutput($sformatf("%s_done@%0d", name, c), log_done[c], (c >= done_from));
      checkOutput($sformatf("%s_rs@%0d", name, c), log_rs[c], t_rs[k]);
      checkOutput($sformatf("%s_data@%0d", name, c), log_data[c], t_data[k]);
    end
  endtask

  task automatic runBatch(input string name);
    int free;
    int req;
    int acc;
    free = 0;
    nt = 0;
    done_from = 0;
    for (int i = 0; i < ns; i++) begin
      applyStimulus(s_rs[i], s_data[i], req, acc);
      obs_acc[i] = acc;
      t_a[i]    = (req > free) ? req : free;
      t_rs[i]   = s_rs[i];
      t_data[i] = s_data[i];
      checkOutput($sformatf("%s_accept%0d", name, i), acc, t_a[i]);
      free = t_a[i] + busyLen(s_rs[i], s_data[i]) + 1;
      nt = i + 1;
      if (s_gap[i] > 0 || i == ns - 1) begin
        wr_valid = 1'b0;
        for (int g = 0; g < s_gap[i]; g++) begin
          wr_rs   = 1'($urandom);
          wr_data = 8'($urandom);
          @(posedge clk);
          #1;
        end
      end
    end
    wr_data = ~wr_data;
    wr_rs   = ~wr_rs;
    checkTimeline(name);
  endtask

  // Offsets in cycles from the accept edge: EN rise, EN width, ready return.
  task automatic measurePulse(input int acc, output int rise, output int width, output int back);
    rise  = -1;
    width = 0;
    back  = -1;
    for (int c = acc; c < acc + 200 && c < cyc && c < MAXC; c++) begin
      if (log_en[c] === 1'b1 && rise < 0) rise = c - acc + 1;
      if (log_en[c] === 1'b1) width++;
      if (log_ready[c] === 1'b1 && back < 0) back = c - acc + 1;
    end
  endtask

  task automatic setStim(input int i, input logic rs, input logic [7:0] d, input int gap);
    s_rs[i]   = rs;
    s_data[i] = d;
    s_gap[i]  = gap;
  endtask

`ifdef LCD_INIT_EN
  // Called on the falling edge where reset is released. Predicts the
  // power-on wait plus six chained init writes, while a data request is
  // held pending that must only be taken once init has completed.
  task automatic checkInit();
    int r0;
    int a;
    int req;
    int acc;
    r0 = cyc;
    a  = r0 + TP;
    for (int i = 0; i < 6; i++) begin
      t_a[i]    = a;
      t_rs[i]   = 1'b0;
      t_data[i] = init_tbl[i];
      a += busyLen(1'b0, init_tbl[i]);
    end
    done_from = a;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h55, req, acc);
    wr_valid  = 1'b0;
    t_a[6]    = (req > a + 1) ? req : a + 1;
    t_rs[6]   = 1'b1;
    t_data[6] = 8'h55;
    nt = 7;
    checkOutput("init_req_accept", acc, t_a[6]);
    checkTimeline("init");
    for (int c = r0; c < r0 + TP; c++) begin
      checkOutput($sformatf("pwr_en@%0d", c), log_en[c], 0);
      checkOutput($sformatf("pwr_data@%0d", c), log_data[c], 0);
      checkOutput($sformatf("pwr_ready@%0d", c), log_ready[c], 0);
      checkOutput($sformatf("pwr_done@%0d", c), log_done[c], 0);
    end
  endtask
`endif

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
`ifdef LCD_INIT_EN
    checkInit();
`else
    checkOutput("rel_ready_before_edge", wr_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("rel_ready", wr_ready, 1);
    checkOutput("rel_done", init_done, 1);
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rise;
    int width;
    int back;
    int req;
    int acc;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", wr_ready, 0);
    checkOutput("rst_done", init_done, 0);
    checkOutput("rst_data", LCD_Data, 8'h00);
    checkOutput("rst_en", LCD_EN, 0);
    checkOutput("rst_rs", LCD_RS, 0);
    checkOutput("rst_rw", LCD_RW, 0);
    checkOutput("rst_on", LCD_on, 1);
    releaseReset();

    ns = 1;
    setStim(0, 1'b1, 8'h41, 0);
    runBatch("t1");
    measurePulse(obs_acc[0], rise, width, back);
    checkOutput("t1_en_rise", rise, 3);
    checkOutput("t1_en_width", width, 3);
    checkOutput("t1_ready_back", back, 13);

    setStim(0, 1'b0, 8'h01, 0);
    runBatch("t2clr");
    measurePulse(obs_acc[0], rise, width, back);
    checkOutput("t2_clr_ready_back", back, 28);

    setStim(0, 1'b1, 8'h01, 0);
    runBatch("t2data");
    measurePulse(obs_acc[0], rise, width, back);
    checkOutput("t2_data01_ready_back", back, 13);

    setStim(0, 1'b0, 8'h02, 0);
    runBatch("t2home");
    measurePulse(obs_acc[0], rise, width, back);
    checkOutput("t2_home_ready_back", back, 28);

    ns = 3;
    setStim(0, 1'b1, 8'h48, 0);
    setStim(1, 1'b1, 8'h49, 0);
    setStim(2, 1'b1, 8'h21, 0);
    runBatch("t3");
    checkOutput("t3_spacing01", obs_acc[1] - obs_acc[0], 13);
    checkOutput("t3_spacing12", obs_acc[2] - obs_acc[1], 13);

    ns = 24;
    for (int i = 0; i < ns; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      setStim(i, 1'($urandom), d, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0);
    end
    runBatch("rnd");

    applyStimulus(1'b0, 8'h38, req, acc);
    wr_valid = 1'b0;
    repeat (S + 2) @(negedge clk);
    checkOutput("t5_en_before_rst", LCD_EN, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_en", LCD_EN, 0);
    checkOutput("t5_ready", wr_ready, 0);
    checkOutput("t5_done", init_done, 0);
    checkOutput("t5_data", LCD_Data, 8'h00);
    @(negedge clk);
    checkOutput("t5_en_held", LCD_EN, 0);
    releaseReset();

    ns = 1;
    setStim(0, 1'b1, 8'h4F, 0);
    runBatch("t5after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

- HD44780-style character-LCD write controller placed between `myProc`'s output port and the LCD pins.
- Replaces software bit-banging of `LCD_EN`/`LCD_RS`. Accepts one command or data byte per valid/ready handshake and generates the setup / enable-pulse / hold / execution-wait sequence with cycle counters.
- Optionally runs the power-on initialisation sequence itself.

## Interface

Parameters (cycle counts at `clk`; defaults sized for 50 MHz):
- `CNT_W`, 20: width of the delay counter; every `T_*` must be ≤ 2^CNT_W−1.
- `T_SETUP`, 4: cycles RS/data are stable before `LCD_EN` rises (≥1).
- `T_EN`, 25: cycles `LCD_EN` is high (≥1).
- `T_HOLD`, 4: cycles RS/data are held after `LCD_EN` falls (≥1).
- `T_CMD`, 2500: execution wait after an ordinary command or data write (≥1).
- `T_CLR`, 100000: execution wait after clear (0x01) or home (0x02) with RS=0 (≥1).
- `T_PWR`, 1000000: power-on wait before init writes; used only with `LCD_INIT_EN`.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: requester has a byte to write.
- `wr_rs` in 1: 0 = command, 1 = data.
- `wr_data` in 8: byte to write.
- `wr_ready` out 1: controller is idle; the transfer occurs on an edge with `wr_valid & wr_ready`. Reset value 0.
- `init_done` out 1: initialisation complete. Reset value 0.
- `LCD_Data` out 8: LCD data bus, registered. Reset value 0x00.
- `LCD_EN` out 1: enable strobe, registered. Reset value 0.
- `LCD_RS` out 1: register select, registered. Reset value 0.
- `LCD_RW` out 1: tied 0 (write-only).
- `LCD_on` out 1: tied 1.

## Operation

States: PWR_WAIT, IDLE, SETUP, PULSE, HOLD, WAIT.
- Reset enters PWR_WAIT with `LCD_INIT_EN`, otherwise IDLE.
- `wr_ready` is 1 only in IDLE after `init_done` = 1.
- Accept in IDLE: `wr_rs`/`wr_data` are latched into the output registers, the counter is loaded, and the FSM goes to SETUP. Later changes on the write inputs are ignored.
- SETUP, T_SETUP cycles: `LCD_EN` = 0, RS/data driven. Then PULSE.
- PULSE, T_EN cycles: `LCD_EN` = 1. Then HOLD.
- HOLD, T_HOLD cycles: `LCD_EN` = 0, RS/data unchanged. Then WAIT.
- WAIT: lasts T_CLR if the latched RS = 0 and the byte is 0x01 or 0x02, otherwise T_CMD. Then IDLE, or the next init step during init.
- Data writes (RS=1) of 0x01/0x02 use T_CMD.
- `LCD_Data`/`LCD_RS` keep their last value in IDLE.
- `wr_valid` outside IDLE is ignored. There is no queue and no drop flag; the requester holds `wr_valid` until accepted.
- Counter: load N−1 on state entry, decrement, leave the state when it reaches 0. This gives exactly N cycles per state.
- Reset mid-operation: `LCD_EN` drops to 0 asynchronously, the byte in flight is discarded, and the FSM restarts from its reset state.

## Timing

- Accept edge at cycle k.
- SETUP occupies k+1 .. k+T_SETUP.
- `LCD_EN` is high for cycles k+1+T_SETUP .. k+T_SETUP+T_EN.
- `wr_ready` returns to 1 at cycle k+1+T_SETUP+T_EN+T_HOLD+T_WAIT.
- `wr_valid` held high continuously: back-to-back accepts are spaced exactly T_SETUP+T_EN+T_HOLD+T_WAIT+1 cycles.
- Without the macro, `wr_ready` and `init_done` go 1 on the first edge after `rst` deasserts.

## Configuration

- `LCD_INIT_EN` defined:
  - After reset, PWR_WAIT for T_PWR cycles.
  - Then command writes (RS=0) 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01, each through the full SETUP/PULSE/HOLD/WAIT path. The 0x01 step waits T_CLR.
  - `init_done` and `wr_ready` rise on entry to IDLE after the last step. Requests during init are not accepted.
  - The sequence is held in an internal 6-entry constant table with a 3-bit index.
- `LCD_INIT_EN` not defined: no PWR_WAIT and no table. `init_done` = 1 after reset; software performs the initialisation.

## Test plan

Bench parameters: T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=5, T_CLR=20, T_PWR=10.

1. No macro: write RS=1, data 0x41. Expect `LCD_EN` high exactly 3 cycles starting 3 cycles after accept, RS=1 and data 0x41 stable from 2 cycles before the rise to 2 cycles after the fall, and `wr_ready` back 13 cycles after accept.
2. No macro: command 0x01 → `wr_ready` back 28 cycles after accept. Data (RS=1) 0x01 → 13 cycles.
3. `wr_valid` held high with three bytes 0x48, 0x49, 0x21 presented in order → three EN pulses 13 cycles apart, bytes in order. Changing `wr_data` mid-transfer has no effect on the bus.
4. With macro: release reset → 10 cycles idle bus, then six EN pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 with RS=0. `init_done` = `wr_ready` = 1 only after the final 20-cycle wait. `wr_valid` asserted during init is not accepted.
5. Assert `rst` during PULSE → `LCD_EN`, `wr_ready`, `init_done` = 0 immediately and `LCD_Data` = 0x00. After release, normal reset behaviour per macro setting.
